pcs_scrambler_pipe: RTL and testbench

//  Parametrised, pipelined self-synchronous scrambler/descrambler for the 40G/100G PCS,
//  g(x) = x^58 + x^39 + 1, processing DATA_WIDTH bits per beat.

---
 rtl/pcs_scrambler_pipe_if.sv | 26 ++
 rtl/pcs_scrambler_pipe.sv | 108 ++++++++++
 tb/tb_pcs_scrambler_pipe.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pcs_scrambler_pipe_if.sv
// Beat stream, seed control and lock status of the PCS scrambler/descrambler.
// The master side drives beats and seeds; the slave side is the scrambler block.
interface pcs_scrambler_pipe_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_bypass;
    logic                  seed_load;
    logic [57:0]           seed_value;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  locked;

    modport master (
        output in_data, in_valid, in_bypass, seed_load, seed_value, out_ready,
        input  in_ready, out_data, out_valid, locked
    );

    modport slave (
        input  in_data, in_valid, in_bypass, seed_load, seed_value, out_ready,
        output in_ready, out_data, out_valid, locked
    );
endinterface

// File: rtl/pcs_scrambler_pipe.sv
// Self-synchronous x^58 + x^39 + 1 scrambler/descrambler, DATA_WIDTH bits per beat,
// one-cycle latency with valid/ready flow control, seed load, bypass and lock tracking.
module pcs_scrambler_pipe #(
    parameter int          DATA_WIDTH = 64,
    parameter bit          DESCRAMBLE = 1'b0,
    parameter logic [57:0] SEED_RESET = 58'h3FF_FFFF_FFFF_FFFF
) (
    input logic                CLK,
    input logic                rst,
    pcs_scrambler_pipe_if.slave bus
);
    localparam int         EXT_W    = 58 + DATA_WIDTH;
    localparam logic [6:0] LOCK_CNT = 7'd58;

    logic [57:0]           hist_q, hist_d;
    logic [6:0]            cnt_q, cnt_d;
    logic                  locked_q, locked_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    logic                  in_ready;
    logic                  accept;
    logic [57:0]           base_hist;
    logic [EXT_W-1:0]      line_bits;
    logic [DATA_WIDTH-1:0] beat_out;
    logic [57:0]           beat_hist;
    logic                  fb;
    logic [6:0]            base_cnt;
    logic [10:0]           cnt_sum;
    logic [6:0]            cnt_sat;

    assign in_ready = ~out_valid_q | bus.out_ready;
    assign accept   = bus.in_valid & in_ready;

    // line_bits is the line stream in time order: [57:0] is the history (oldest at 0),
    // [58+n] is line bit n of this beat, so s[n-58] = line_bits[n], s[n-39] = line_bits[n+19].
    always_comb begin
        base_hist         = bus.seed_load ? bus.seed_value : hist_q;
        line_bits         = '0;
        line_bits[57:0]   = base_hist;
        beat_out          = '0;
        fb                = 1'b0;
        for (int n = 0; n < DATA_WIDTH; n++) begin
            fb = line_bits[n + 19] ^ line_bits[n];
            if (bus.in_bypass) begin
                beat_out[n]       = bus.in_data[n];
                line_bits[58 + n] = bus.in_data[n];
            end else if (DESCRAMBLE) begin
                beat_out[n]       = bus.in_data[n] ^ fb;
                line_bits[58 + n] = bus.in_data[n];
            end else begin
                beat_out[n]       = bus.in_data[n] ^ fb;
                line_bits[58 + n] = beat_out[n];
            end
        end
        beat_hist = line_bits[EXT_W-1 -: 58];
    end

    // A seed counts as fully known history, so loading one saturates the lock counter.
    always_comb begin
        base_cnt = bus.seed_load ? LOCK_CNT : cnt_q;
        cnt_sum  = {4'b0, base_cnt} + 11'(DATA_WIDTH);
        cnt_sat  = (cnt_sum >= 11'd58) ? LOCK_CNT : cnt_sum[6:0];
    end

    always_comb begin
        hist_d      = hist_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            hist_d      = beat_hist;
            cnt_d       = cnt_sat;
            out_data_d  = beat_out;
            out_valid_d = 1'b1;
        end else begin
            if (bus.out_ready) begin
                out_valid_d = 1'b0;
            end
            if (bus.seed_load) begin
                hist_d = bus.seed_value;
                cnt_d  = LOCK_CNT;
            end
        end
        locked_d = DESCRAMBLE ? (cnt_d == LOCK_CNT) : 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            hist_q      <= SEED_RESET;
            cnt_q       <= '0;
            locked_q    <= ~DESCRAMBLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            hist_q      <= hist_d;
            cnt_q       <= cnt_d;
            locked_q    <= locked_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.locked    = locked_q;
endmodule

// File: tb/tb_pcs_scrambler_pipe.sv
// Directed and loopback checks of pcs_scrambler_pipe at W=64 and W=16 in both modes,
// against hand-computed vectors and a bit-serial shift-register reference.
module tb_pcs_scrambler_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    pcs_scrambler_pipe_if #(.DATA_WIDTH(64)) if_s64 ();
    pcs_scrambler_pipe_if #(.DATA_WIDTH(64)) if_d64 ();
    pcs_scrambler_pipe_if #(.DATA_WIDTH(16)) if_s16 ();
    pcs_scrambler_pipe_if #(.DATA_WIDTH(16)) if_d16 ();

    pcs_scrambler_pipe #(.DATA_WIDTH(64), .DESCRAMBLE(1'b0)) u_s64 (.CLK(clk), .rst(rst), .bus(if_s64));
    pcs_scrambler_pipe #(.DATA_WIDTH(64), .DESCRAMBLE(1'b1)) u_d64 (.CLK(clk), .rst(rst), .bus(if_d64));
    pcs_scrambler_pipe #(.DATA_WIDTH(16), .DESCRAMBLE(1'b0)) u_s16 (.CLK(clk), .rst(rst), .bus(if_s16));
    pcs_scrambler_pipe #(.DATA_WIDTH(16), .DESCRAMBLE(1'b1)) u_d16 (.CLK(clk), .rst(rst), .bus(if_d16));

    typedef struct {
        int          which;   // 0 s64, 1 d64, 2 s16, 3 d16
        logic [57:0] seed;
        logic [63:0] din;
        logic        byp;
        logic [63:0] exp;
    } vec_t;

    localparam int NV = 10;
    localparam int NL = 1000;
    vec_t        vecs [NV];
    logic [63:0] lb_data [NL];
    logic [63:0] lb_scr  [NL];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Bit-serial reference: sh[57] newest line bit, shifted right once per bit.
    function automatic logic [63:0] ref_beat(input int w, input bit desc, input bit byp,
                                             input logic [57:0] s_in, input logic [63:0] d,
                                             output logic [57:0] s_out);
        logic [57:0] sh;
        logic [63:0] o;
        logic        lb, fb;
        sh = s_in;
        o  = '0;
        for (int n = 0; n < w; n++) begin
            fb = sh[19] ^ sh[0];
            if (byp) begin
                o[n] = d[n];
                lb   = d[n];
            end else begin
                o[n] = d[n] ^ fb;
                lb   = desc ? d[n] : o[n];
            end
            sh = {lb, sh[57:1]};
        end
        s_out = sh;
        return o;
    endfunction

    task automatic drive(input int which, input logic vld, input logic [63:0] d,
                         input logic byp, input logic ld, input logic [57:0] seed);
        case (which)
            0: begin if_s64.in_valid = vld; if_s64.in_data = d; if_s64.in_bypass = byp;
                     if_s64.seed_load = ld; if_s64.seed_value = seed; end
            1: begin if_d64.in_valid = vld; if_d64.in_data = d; if_d64.in_bypass = byp;
                     if_d64.seed_load = ld; if_d64.seed_value = seed; end
            2: begin if_s16.in_valid = vld; if_s16.in_data = d[15:0]; if_s16.in_bypass = byp;
                     if_s16.seed_load = ld; if_s16.seed_value = seed; end
            default: begin if_d16.in_valid = vld; if_d16.in_data = d[15:0]; if_d16.in_bypass = byp;
                     if_d16.seed_load = ld; if_d16.seed_value = seed; end
        endcase
    endtask

    task automatic sample(input int which, output logic [63:0] o, output logic v,
                          output logic lk, output logic rdy);
        case (which)
            0: begin o = if_s64.out_data; v = if_s64.out_valid; lk = if_s64.locked; rdy = if_s64.in_ready; end
            1: begin o = if_d64.out_data; v = if_d64.out_valid; lk = if_d64.locked; rdy = if_d64.in_ready; end
            2: begin o = {48'b0, if_s16.out_data}; v = if_s16.out_valid; lk = if_s16.locked; rdy = if_s16.in_ready; end
            default: begin o = {48'b0, if_d16.out_data}; v = if_d16.out_valid; lk = if_d16.locked; rdy = if_d16.in_ready; end
        endcase
    endtask

    // Present one request for one clock edge, then sample and withdraw it.
    task automatic step(input int which, input logic vld, input logic [63:0] d, input logic byp,
                        input logic ld, input logic [57:0] seed,
                        output logic [63:0] o, output logic v, output logic lk);
        logic rdy;
        drive(which, vld, d, byp, ld, seed);
        @(posedge clk);
        #1;
        sample(which, o, v, lk, rdy);
        drive(which, 1'b0, d, 1'b0, 1'b0, seed);
    endtask

    task automatic do_reset();
        for (int k = 0; k < 4; k++) drive(k, 1'b0, 64'h0, 1'b0, 1'b0, 58'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic loopback(input int sc, input int w);
        logic [63:0] o, mask;
        logic        v, lk, rdy;
        logic [57:0] rs;
        int          errs, ncmp;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_0000_FFFF;
        do_reset();
        rs = 58'({$urandom(), $urandom()});
        step(sc, 1'b0, 64'h0, 1'b0, 1'b1, rs, o, v, lk);
        for (int k = 0; k < NL; k++) begin
            lb_data[k] = {$urandom(), $urandom()} & mask;
            step(sc, 1'b1, lb_data[k], 1'b0, 1'b0, 58'h0, o, v, lk);
            lb_scr[k] = o;
        end
        errs = 0;
        ncmp = 0;
        for (int k = 0; k < NL; k++) begin
            sample(sc + 1, o, v, lk, rdy);
            step(sc + 1, 1'b1, lb_scr[k], 1'b0, 1'b0, 58'h0, o, v, lk);
            if (lk === 1'b1 || (k > 0 && ncmp > 0)) begin end
            sample(sc + 1, o, v, lk, rdy);
            if (k >= ((w == 64) ? 1 : 4)) begin
                ncmp++;
                if (o !== lb_data[k]) errs++;
            end
        end
        chk($sformatf("loopback W=%0d mismatching beats", w), 64'(errs), 64'd0);
    endtask

    initial begin
        logic [63:0] o, e;
        logic        v, lk, rdy;
        logic [57:0] s_model, s_tmp;

        vecs[0] = '{0, 58'h0, 64'h0000_0000_0000_0001, 1'b0, 64'h0400_0080_0000_0001};
        vecs[1] = '{0, 58'h0, 64'h0000_0000_0000_0000, 1'b0, 64'h0000_0000_0000_0000};
        vecs[2] = '{0, 58'h0, 64'h8000_0000_0000_0000, 1'b0, 64'h8000_0000_0000_0000};
        vecs[3] = '{0, 58'h1, 64'h0000_0000_0000_0000, 1'b0, 64'h0400_0080_0000_0001};
        vecs[4] = '{0, 58'h200_0000_0000_0000, 64'h0, 1'b0, 64'h0200_0040_0000_0000};
        vecs[5] = '{1, 58'h0, 64'h0400_0080_0000_0001, 1'b0, 64'h0000_0000_0000_0001};
        vecs[6] = '{1, 58'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFC00_007F_FFFF_FFFF};
        vecs[7] = '{0, 58'h3FF_FFFF_FFFF_FFFF, 64'hDEAD_BEEF_0000_FFFF, 1'b1, 64'hDEAD_BEEF_0000_FFFF};
        vecs[8] = '{2, 58'h3FF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_ABCD, 1'b0, 64'h0000_0000_0000_ABCD};
        vecs[9] = '{3, 58'h0_0000_0008_0000, 64'h0000_0000_0000_0000, 1'b0, 64'h0000_0000_0000_0001};

        if_s64.out_ready = 1'b1; if_d64.out_ready = 1'b1;
        if_s16.out_ready = 1'b1; if_d16.out_ready = 1'b1;
        do_reset();

        for (int k = 0; k < 4; k++) begin
            sample(k, o, v, lk, rdy);
            chk($sformatf("reset%0d out_valid", k), {63'b0, v}, 64'd0);
            chk($sformatf("reset%0d out_data", k), o, 64'd0);
            chk($sformatf("reset%0d locked", k), {63'b0, lk}, (k % 2 == 0) ? 64'd1 : 64'd0);
            chk($sformatf("reset%0d in_ready", k), {63'b0, rdy}, 64'd1);
        end

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].which, 1'b1, vecs[i].din, vecs[i].byp, 1'b1, vecs[i].seed, o, v, lk);
            chk($sformatf("vec%0d out_data", i), o, vecs[i].exp);
            chk($sformatf("vec%0d out_valid", i), {63'b0, v}, 64'd1);
        end

        // Seed load alone, then one beat: output and resulting history.
        do_reset();
        step(0, 1'b0, 64'h0, 1'b0, 1'b1, 58'h0, o, v, lk);
        step(0, 1'b1, 64'h1, 1'b0, 1'b0, 58'h0, o, v, lk);
        chk("s64 seed0 beat out", o, 64'h0400_0080_0000_0001);
        chk("s64 seed0 beat hist", {6'b0, u_s64.hist_q}, {6'b0, 58'h0010_0002_0000_0000});
        step(1, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, 58'h0, o, v, lk);
        chk("d64 locked after first beat", {63'b0, lk}, 64'd1);

        // Backpressure: five stalled cycles, then release without loss or duplication.
        do_reset();
        step(0, 1'b0, 64'h0, 1'b0, 1'b1, 58'h0, o, v, lk);
        s_model = 58'h0;
        if_s64.out_ready = 1'b0;
        step(0, 1'b1, 64'hA5A5_0000_1111_2222, 1'b0, 1'b0, 58'h0, o, v, lk);
        e = ref_beat(64, 1'b0, 1'b0, s_model, 64'hA5A5_0000_1111_2222, s_model);
        chk("bp beat A", o, e);
        drive(0, 1'b1, 64'h0F0F_3333_4444_5555, 1'b0, 1'b0, 58'h0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            sample(0, o, v, lk, rdy);
            chk($sformatf("bp stall%0d in_ready", c), {63'b0, rdy}, 64'd0);
            chk($sformatf("bp stall%0d out_data", c), o, e);
            chk($sformatf("bp stall%0d hist", c), {6'b0, u_s64.hist_q}, {6'b0, s_model});
        end
        if_s64.out_ready = 1'b1;
        @(posedge clk);
        #1;
        sample(0, o, v, lk, rdy);
        drive(0, 1'b0, 64'h0, 1'b0, 1'b0, 58'h0);
        e = ref_beat(64, 1'b0, 1'b0, s_model, 64'h0F0F_3333_4444_5555, s_model);
        chk("bp beat B after release", o, e);
        step(0, 1'b1, 64'h7777_8888_9999_AAAA, 1'b0, 1'b0, 58'h0, o, v, lk);
        e = ref_beat(64, 1'b0, 1'b0, s_model, 64'h7777_8888_9999_AAAA, s_model);
        chk("bp beat C", o, e);

        // Bypass mid-stream; the following beat must see the bypassed bits as history.
        step(0, 1'b1, 64'hDEAD_BEEF_0000_FFFF, 1'b1, 1'b0, 58'h0, o, v, lk);
        e = ref_beat(64, 1'b0, 1'b1, s_model, 64'hDEAD_BEEF_0000_FFFF, s_model);
        chk("bypass beat out", o, 64'hDEAD_BEEF_0000_FFFF);
        step(0, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 58'h0, o, v, lk);
        e = ref_beat(64, 1'b0, 1'b0, s_model, 64'h0123_4567_89AB_CDEF, s_model);
        chk("beat after bypass", o, e);
        step(0, 1'b0, 64'h0, 1'b0, 1'b0, 58'h0, o, v, lk);
        chk("drain out_valid", {63'b0, v}, 64'd0);

        // Reset while a beat is held under backpressure.
        if_s64.out_ready = 1'b0;
        step(0, 1'b1, 64'h5555_AAAA_5555_AAAA, 1'b0, 1'b0, 58'h0, o, v, lk);
        do_reset();
        sample(0, o, v, lk, rdy);
        chk("midreset out_valid", {63'b0, v}, 64'd0);
        chk("midreset out_data", o, 64'd0);
        if_s64.out_ready = 1'b1;

        // W=16 descrambler lock: 16, 32, 48, 64 bits seen.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(3, 1'b1, 64'(16'h1357 + i), 1'b0, 1'b0, 58'h0, o, v, lk);
            chk($sformatf("d16 locked after beat %0d", i + 1), {63'b0, lk}, (i == 3) ? 64'd1 : 64'd0);
        end
        do_reset();
        step(3, 1'b1, 64'h0001, 1'b0, 1'b1, 58'h0_0000_0008_0000, o, v, lk);
        chk("d16 seed with accept out", o, 64'h0);
        chk("d16 seed with accept locked", {63'b0, lk}, 64'd1);
        s_tmp = 58'h0_0000_0008_0000;
        e = ref_beat(16, 1'b1, 1'b0, s_tmp, 64'h0001, s_tmp);
        step(3, 1'b1, 64'hC3A5, 1'b0, 1'b0, 58'h0, o, v, lk);
        e = ref_beat(16, 1'b1, 1'b0, s_tmp, 64'hC3A5, s_tmp);
        chk("d16 beat after seeded beat", o, e);

        loopback(0, 64);
        loopback(2, 16);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end
endmodule
